id_ex_stage: RTL

//  ID/EX pipeline stage sitting directly upstream of the 2-bit-CTRL alu; registers decoded

---
 rtl/id_ex_stage_if.sv | 47 ++++
 rtl/id_ex_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX stage, the MEM stage and the alu.
// The stage uses the slave modport; whoever feeds it uses master.
interface id_ex_stage_if #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [REG_BITS-1:0] rs_idx;
    logic [WIDTH-1:0]    rs_val;
    logic [REG_BITS-1:0] rt_idx;
    logic [WIDTH-1:0]    rt_val;
    logic [REG_BITS-1:0] rd_idx;
    logic                wr_en;
    logic [WIDTH-1:0]    imm;
    logic                use_imm;
    logic [1:0]          alu_op;
    logic                is_load;
    logic [WIDTH-1:0]    ex_result;
    logic                mem_wr_en;
    logic [REG_BITS-1:0] mem_rd;
    logic [WIDTH-1:0]    mem_result;
    logic                flush;
    logic [WIDTH-1:0]    a_out;
    logic [WIDTH-1:0]    b_out;
    logic [1:0]          ctrl_out;
    logic                ex_valid;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_wr_en;
    logic                ex_is_load;
    logic [CNT_W-1:0]    stall_count;

    modport slave (
        input  in_valid, rs_idx, rs_val, rt_idx, rt_val, rd_idx, wr_en, imm, use_imm,
               alu_op, is_load, ex_result, mem_wr_en, mem_rd, mem_result, flush,
        output in_ready, a_out, b_out, ctrl_out, ex_valid, ex_rd, ex_wr_en, ex_is_load,
               stall_count
    );

    modport master (
        output in_valid, rs_idx, rs_val, rt_idx, rt_val, rd_idx, wr_en, imm, use_imm,
               alu_op, is_load, ex_result, mem_wr_en, mem_rd, mem_result, flush,
        input  in_ready, a_out, b_out, ctrl_out, ex_valid, ex_rd, ex_wr_en, ex_is_load,
               stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the alu: operand forwarding from EX and MEM,
// one-cycle load-use bubble, and branch flush.
module id_ex_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    id_ex_stage_if.slave   bus
);
    typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_hazard;
    logic                w_capture;
    logic                w_stall;
    logic [WIDTH-1:0]    w_rs_fwd;
    logic [WIDTH-1:0]    w_rt_fwd;
    logic [WIDTH-1:0]    w_b_sel;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [1:0]          r_ctrl;
    logic                r_ex_valid;
    logic [REG_BITS-1:0] r_ex_rd;
    logic                r_ex_wr_en;
    logic                r_ex_is_load;
    logic [CNT_W-1:0]    r_stall_count;

    // A load in EX has no data yet; a dependent op must wait one cycle for MEM.
    assign w_hazard = r_ex_valid && r_ex_is_load && r_ex_wr_en && (r_ex_rd != '0) &&
                      bus.in_valid &&
                      ((bus.rs_idx == r_ex_rd) || (!bus.use_imm && (bus.rt_idx == r_ex_rd)));

    assign w_rs_fwd = (bus.rs_idx == '0) ? '0 :
                      (r_ex_valid && r_ex_wr_en && !r_ex_is_load && (r_ex_rd == bus.rs_idx)) ? bus.ex_result :
                      (bus.mem_wr_en && (bus.mem_rd == bus.rs_idx)) ? bus.mem_result :
                      bus.rs_val;

    assign w_rt_fwd = (bus.rt_idx == '0) ? '0 :
                      (r_ex_valid && r_ex_wr_en && !r_ex_is_load && (r_ex_rd == bus.rt_idx)) ? bus.ex_result :
                      (bus.mem_wr_en && (bus.mem_rd == bus.rt_idx)) ? bus.mem_result :
                      bus.rt_val;

    assign w_b_sel = bus.use_imm ? bus.imm : w_rt_fwd;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_stall      = 1'b0;
        if (bus.flush) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        w_stall      = 1'b1;
                        w_state_next = ST_BUBBLE;
                    end else begin
                        w_capture = bus.in_valid;
                    end
                end
                ST_BUBBLE: begin
                    w_capture    = bus.in_valid;
                    w_state_next = ST_RUN;
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    assign bus.in_ready = reset && !bus.flush && ((r_state == ST_BUBBLE) || !w_hazard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_a           <= '0;
            r_b           <= '0;
            r_ctrl        <= '0;
            r_ex_valid    <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_wr_en    <= 1'b0;
            r_ex_is_load  <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (bus.flush) begin
                r_ex_valid   <= 1'b0;
                r_ex_rd      <= '0;
                r_ex_wr_en   <= 1'b0;
                r_ex_is_load <= 1'b0;
            end else if (w_capture) begin
                r_a          <= w_rs_fwd;
                r_b          <= w_b_sel;
                r_ctrl       <= bus.alu_op;
                r_ex_valid   <= 1'b1;
                r_ex_rd      <= bus.rd_idx;
                r_ex_wr_en   <= bus.wr_en;
                r_ex_is_load <= bus.is_load;
            end else begin
                // Operand registers hold so the alu inputs do not toggle on bubbles.
                r_ex_valid <= 1'b0;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign bus.a_out       = r_a;
    assign bus.b_out       = r_b;
    assign bus.ctrl_out    = r_ctrl;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_rd       = r_ex_rd;
    assign bus.ex_wr_en    = r_ex_wr_en;
    assign bus.ex_is_load  = r_ex_is_load;
    assign bus.stall_count = r_stall_count;
endmodule
